// File: rtl/write_back.sv
// write_back: final pipeline stage. Retires instructions from execute into the
// architectural register file, updates the flags field, or performs a single-beat
// memory write with a request/acknowledge handshake.
// Optional build macro WRITE_BACK_STATS_EN adds retired_count and stall_count outputs.
module write_back #(
   parameter int NREGS     = 32,
   parameter int FLAGS_REG = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_is_valid,
   output logic                 in_hold,
   input  logic [31:0]          in_pc,
   input  logic [4:0]           in_destination_register,
   input  logic                 in_is_writing_memory,
   input  logic [3:0]           in_flags,
   input  logic [31:0]          in_destination_value,
   input  logic                 in_has_upper_value,
   input  logic [31:0]          in_upper_value,
   input  logic [31:0]          in_adjustment_value,
   input  logic                 in_has_flushed,
   output logic [NREGS*32-1:0]  registers,
   output logic                 mem_write,
   output logic [31:0]          mem_address,
   output logic [31:0]          mem_data,
   input  logic                 mem_ack,
`ifdef WRITE_BACK_STATS_EN
   output logic [31:0]          retired_count,
   output logic [31:0]          stall_count,
`endif
   output logic [31:0]          retired_pc
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      UPPER    = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [31:0] rf [NREGS];

   logic [31:0] rd_ext;
   logic        rd_in_range;
   logic        rd_writable;
   logic [31:0] rd_value;
   logic        accept;
   logic        accept_live;

   // Pending upper-half write and pending store PC, captured at acceptance
   logic [4:0]  upper_idx;
   logic        upper_en;
   logic [31:0] upper_value;
   logic [31:0] store_pc;

   assign rd_ext      = {27'd0, in_destination_register};
   assign rd_in_range = (rd_ext < 32'(NREGS));
   assign rd_writable = rd_in_range && (in_destination_register != 5'd0);
   // Register 0 is never written, so reading it yields zero naturally
   assign rd_value    = rd_in_range ? rf[in_destination_register] : 32'd0;
   assign accept      = (state == IDLE) && in_is_valid;
   assign accept_live = accept && !in_has_flushed;

   for (genvar g = 0; g < NREGS; g++) begin : g_export
      assign registers[32*g +: 32] = rf[g];
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state decode: stores wait for ack, upper results take one extra cycle
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept_live) begin
               if (in_is_writing_memory)    state_next = MEM_WAIT;
               else if (in_has_upper_value) state_next = UPPER;
            end
         end
         UPPER:    state_next = IDLE;
         MEM_WAIT: if (mem_ack) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Register file, memory request and retirement bookkeeping
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
         in_hold     <= 1'b0;
         mem_write   <= 1'b0;
         mem_address <= '0;
         mem_data    <= '0;
         retired_pc  <= '0;
         upper_en    <= 1'b0;
      end else begin
         in_hold <= (state_next != IDLE);
         case (state)
            IDLE: begin
               if (accept_live) begin
                  if (in_is_writing_memory) begin
                     mem_address <= rd_value + in_adjustment_value;
                     mem_data    <= in_destination_value;
                     mem_write   <= 1'b1;
                     store_pc    <= in_pc;
                  end else begin
                     // Flags first so a destination of FLAGS_REG overrides them
                     rf[FLAGS_REG][30:27] <= in_flags;
                     if (rd_writable) rf[in_destination_register] <= in_destination_value;
                     retired_pc  <= in_pc;
                     upper_idx   <= in_destination_register + 5'd1;
                     upper_en    <= in_has_upper_value && ((rd_ext + 32'd1) < 32'(NREGS));
                     upper_value <= in_upper_value;
                  end
               end
            end
            UPPER: begin
               if (upper_en) rf[upper_idx] <= upper_value;
            end
            MEM_WAIT: begin
               if (mem_ack) begin
                  mem_write  <= 1'b0;
                  retired_pc <= store_pc;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef WRITE_BACK_STATS_EN
   logic retire_now;
   assign retire_now = (accept_live && !in_is_writing_memory) ||
                       ((state == MEM_WAIT) && mem_ack);

   // Retirement and stall event counters
   always_ff @(posedge clock) begin
      if (reset) begin
         retired_count <= '0;
         stall_count   <= '0;
      end else begin
         if (retire_now)             retired_count <= retired_count + 32'd1;
         if (in_hold && in_is_valid) stall_count   <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_write_back.sv
// tb_write_back: directed stimulus for write_back with a cycle-stamped scoreboard
// and a store-handshake scoreboard drained by a separate monitor.
module tb_write_back;

   localparam int NREGS     = 32;
   localparam int FLAGS_REG = 2;

   localparam int S_REG   = 0;
   localparam int S_RPC   = 1;
   localparam int S_HOLD  = 2;
   localparam int S_MWR   = 3;
   localparam int S_MADDR = 4;
   localparam int S_MDATA = 5;
   localparam int S_FLAGS = 6;

   logic                clock = 1'b0;
   logic                reset;
   logic                in_is_valid;
   logic                in_hold;
   logic [31:0]         in_pc;
   logic [4:0]          in_destination_register;
   logic                in_is_writing_memory;
   logic [3:0]          in_flags;
   logic [31:0]         in_destination_value;
   logic                in_has_upper_value;
   logic [31:0]         in_upper_value;
   logic [31:0]         in_adjustment_value;
   logic                in_has_flushed;
   logic [NREGS*32-1:0] registers;
   logic                mem_write;
   logic [31:0]         mem_address;
   logic [31:0]         mem_data;
   logic                mem_ack;
   logic [31:0]         retired_pc;
`ifdef WRITE_BACK_STATS_EN
   logic [31:0]         retired_count;
   logic [31:0]         stall_count;
`endif

   write_back #(.NREGS(NREGS), .FLAGS_REG(FLAGS_REG)) dut (
      .clock                   (clock),
      .reset                   (reset),
      .in_is_valid             (in_is_valid),
      .in_hold                 (in_hold),
      .in_pc                   (in_pc),
      .in_destination_register (in_destination_register),
      .in_is_writing_memory    (in_is_writing_memory),
      .in_flags                (in_flags),
      .in_destination_value    (in_destination_value),
      .in_has_upper_value      (in_has_upper_value),
      .in_upper_value          (in_upper_value),
      .in_adjustment_value     (in_adjustment_value),
      .in_has_flushed          (in_has_flushed),
      .registers               (registers),
      .mem_write               (mem_write),
      .mem_address             (mem_address),
      .mem_data                (mem_data),
      .mem_ack                 (mem_ack),
`ifdef WRITE_BACK_STATS_EN
      .retired_count           (retired_count),
      .stall_count             (stall_count),
`endif
      .retired_pc              (retired_pc)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int          at;
      int          sel;
      int          idx;
      logic [31:0] val;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } store_t;

   exp_t   exp_q[$];
   store_t store_q[$];
   int     checks = 0;
   int     errors = 0;

   function automatic string sel_name(input int sel);
      case (sel)
         S_REG:   return "reg";
         S_RPC:   return "retired_pc";
         S_HOLD:  return "in_hold";
         S_MWR:   return "mem_write";
         S_MADDR: return "mem_address";
         S_MDATA: return "mem_data";
         S_FLAGS: return "flags";
         default: return "unknown";
      endcase
   endfunction

   function automatic logic [31:0] observe(input int sel, input int idx);
      case (sel)
         S_REG:   return registers[idx*32 +: 32];
         S_RPC:   return retired_pc;
         S_HOLD:  return {31'd0, in_hold};
         S_MWR:   return {31'd0, mem_write};
         S_MADDR: return mem_address;
         S_MDATA: return mem_data;
         S_FLAGS: return {28'd0, registers[FLAGS_REG*32+27 +: 4]};
         default: return 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic ex(input int dt, input int sel, input int idx, input logic [31:0] v);
      exp_t e;
      e.at = cyc + dt; e.sel = sel; e.idx = idx; e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                        input logic wm, input logic [3:0] fl, input logic [31:0] val,
                        input logic hu, input logic [31:0] uv, input logic [31:0] adj,
                        input logic fsh);
      in_is_valid             = v;
      in_pc                   = pc;
      in_destination_register = rd;
      in_is_writing_memory    = wm;
      in_flags                = fl;
      in_destination_value    = val;
      in_has_upper_value      = hu;
      in_upper_value          = uv;
      in_adjustment_value     = adj;
      in_has_flushed          = fsh;
   endtask

   // Monitor: drains stamped expectations and completed store handshakes
   always @(negedge clock) begin
      int          i;
      logic [31:0] got;
      store_t      s;
      i = 0;
      while (i < exp_q.size()) begin
         if (exp_q[i].at == cyc) begin
            got = observe(exp_q[i].sel, exp_q[i].idx);
            checks++;
            if (got !== exp_q[i].val) begin
               errors++;
               $display("FAIL %s[%0d] cyc=%0d: got %h, expected %h",
                        sel_name(exp_q[i].sel), exp_q[i].idx, cyc, got, exp_q[i].val);
            end
            exp_q.delete(i);
         end else begin
            i++;
         end
      end
      if (mem_write && mem_ack) begin
         if (store_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL store_unexpected cyc=%0d: got addr %h data %h, expected no store",
                     cyc, mem_address, mem_data);
         end else begin
            s = store_q.pop_front();
            checks += 2;
            if (mem_address !== s.addr) begin
               errors++;
               $display("FAIL store_addr cyc=%0d: got %h, expected %h", cyc, mem_address, s.addr);
            end
            if (mem_data !== s.data) begin
               errors++;
               $display("FAIL store_data cyc=%0d: got %h, expected %h", cyc, mem_data, s.data);
            end
         end
      end
   end

   initial begin
      store_t st;
      reset   = 1'b1;
      mem_ack = 1'b0;
      drive(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
      step();
      step();

      // Reset state, then a plain ALU instruction rd=5
      ex(0, S_HOLD, 0, 0);  ex(0, S_MWR, 0, 0);   ex(0, S_RPC, 0, 0);
      ex(0, S_MADDR, 0, 0); ex(0, S_REG, 5, 0);   ex(0, S_REG, FLAGS_REG, 0);
      reset = 1'b0;
      drive(1, 32'h100, 5, 0, 4'b1001, 32'h1234_5678, 0, 0, 0, 0);
      ex(1, S_REG, 5, 32'h1234_5678); ex(1, S_FLAGS, 0, 4'b1001);
      ex(1, S_RPC, 0, 32'h100);       ex(1, S_HOLD, 0, 0);
      step();

      // Upper instruction rd=7
      drive(1, 32'h104, 7, 0, 4'b0110, 32'hDEAD_BEEF, 1, 32'h1, 0, 0);
      ex(1, S_REG, 7, 32'hDEAD_BEEF); ex(1, S_FLAGS, 0, 4'b0110);
      ex(1, S_HOLD, 0, 1);            ex(1, S_RPC, 0, 32'h104);
      ex(1, S_REG, 8, 0);
      ex(2, S_REG, 8, 32'h1);         ex(2, S_HOLD, 0, 0);
      step();

      // Upper instruction rd=31 presented during the stall; held until IDLE
      drive(1, 32'h108, 31, 0, 4'b0110, 32'h55, 1, 32'h77, 0, 0);
      ex(1, S_RPC, 0, 32'h104); ex(1, S_REG, 31, 0);
      step();
      ex(1, S_REG, 31, 32'h55); ex(1, S_HOLD, 0, 1); ex(1, S_RPC, 0, 32'h108);
      ex(2, S_HOLD, 0, 0);      ex(2, S_REG, 0, 0);  ex(2, S_REG, 1, 0);
      ex(2, S_REG, 30, 0);
      step();
      in_is_valid = 1'b0;
      step();

      // reg3 = 0x1000, then store via rd=3 with offset 0x10
      drive(1, 32'h10C, 3, 0, 4'b1100, 32'h1000, 0, 0, 0, 0);
      ex(1, S_REG, 3, 32'h1000); ex(1, S_FLAGS, 0, 4'b1100);
      step();
      drive(1, 32'h110, 3, 1, 4'b0011, 32'hAA, 0, 0, 32'h10, 0);
      ex(1, S_MWR, 0, 1);   ex(1, S_MADDR, 0, 32'h1010); ex(1, S_MDATA, 0, 32'hAA);
      ex(1, S_HOLD, 0, 1);  ex(1, S_FLAGS, 0, 4'b1100);  ex(1, S_RPC, 0, 32'h10C);
      st.addr = 32'h1010; st.data = 32'hAA;
      store_q.push_back(st);
      step();
      ex(1, S_MWR, 0, 1);
      step();
      ex(1, S_MWR, 0, 1); ex(1, S_HOLD, 0, 1);
      step();
      mem_ack = 1'b1;
      ex(0, S_MWR, 0, 1);
      ex(1, S_MWR, 0, 0); ex(1, S_HOLD, 0, 0); ex(1, S_RPC, 0, 32'h110);
      ex(1, S_FLAGS, 0, 4'b1100);
      step();
      mem_ack = 1'b0;

      // Flushed rd=4 then plain rd=4 value 9
      drive(1, 32'h200, 4, 0, 4'b1111, 32'h33, 0, 0, 0, 1);
      ex(1, S_REG, 4, 0); ex(1, S_RPC, 0, 32'h110); ex(1, S_FLAGS, 0, 4'b1100);
      ex(1, S_MWR, 0, 0);
      step();
      drive(1, 32'h204, 4, 0, 4'b0001, 32'h9, 0, 0, 0, 0);
      ex(1, S_REG, 4, 32'h9); ex(1, S_RPC, 0, 32'h204); ex(1, S_FLAGS, 0, 4'b0001);
      step();

      // Destination = FLAGS_REG overrides the flags write
      drive(1, 32'h208, FLAGS_REG, 0, 4'b1111, 32'hCAFE_0000, 0, 0, 0, 0);
      ex(1, S_REG, FLAGS_REG, 32'hCAFE_0000);
      step();

      // Failed conditional store: rd=0, only flags change
      drive(1, 32'h20C, 0, 0, 4'b1010, 32'hFFFF, 0, 0, 0, 0);
      ex(1, S_REG, 0, 0); ex(1, S_REG, FLAGS_REG, 32'hD2FE_0000); ex(1, S_RPC, 0, 32'h20C);
      step();

      // Store from reg7 with offset 1, then reset while in MEM_WAIT
      drive(1, 32'h300, 7, 1, 4'b0000, 32'h5, 0, 0, 32'h1, 0);
      ex(1, S_MWR, 0, 1); ex(1, S_MADDR, 0, 32'hDEAD_BEF0); ex(1, S_HOLD, 0, 1);
      step();
      reset = 1'b1;
      in_is_valid = 1'b0;
      ex(1, S_MWR, 0, 0);   ex(1, S_HOLD, 0, 0); ex(1, S_REG, 7, 0); ex(1, S_REG, 3, 0);
      ex(1, S_RPC, 0, 0);   ex(1, S_MADDR, 0, 0); ex(1, S_REG, FLAGS_REG, 0);
      step();
      reset = 1'b0;
      drive(1, 32'h400, 6, 0, 4'b0101, 32'h66, 0, 0, 0, 0);
      ex(1, S_REG, 6, 32'h66); ex(1, S_RPC, 0, 32'h400); ex(1, S_FLAGS, 0, 4'b0101);
      ex(1, S_HOLD, 0, 0);
      step();

      // mem_ack outside MEM_WAIT has no effect
      in_is_valid = 1'b0;
      mem_ack     = 1'b1;
      ex(1, S_MWR, 0, 0); ex(1, S_HOLD, 0, 0); ex(1, S_RPC, 0, 32'h400);
      step();
      mem_ack = 1'b0;
      step();
      step();
      step();

      if (exp_q.size() != 0) begin
         checks += exp_q.size();
         errors += exp_q.size();
         $display("FAIL pending_checks: got %0d unchecked, expected 0", exp_q.size());
      end
      if (store_q.size() != 0) begin
         checks += store_q.size();
         errors += store_q.size();
         $display("FAIL pending_stores: got %0d unacknowledged, expected 0", store_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/write_back.md
Name: write_back

Overview:
- Final pipeline stage and the consumer of the execute-to-write interface.
- Retires each instruction presented by execute:
  - writes the destination register (and, for mul/div, the upper result into the next register);
  - updates the flags field;
  - or issues a single-beat memory write with a request/acknowledge handshake.
- Owns the architectural register file and exports it to the read and execute stages.

Parameters:
- NREGS, 32, number of architectural registers; register 0 reads as zero and ignores writes.
- FLAGS_REG, 2, index of the Flags register.

Ports:
- clock  input  1  stage clock
- reset  input  1  synchronous active-high reset
- in_is_valid  input  1  execute presents a valid instruction
- in_hold  output  1  stall to execute; execute keeps its outputs unchanged while high
- in_pc  input  32  program counter of the instruction
- in_destination_register  input  5  destination register, or address register when in_is_writing_memory=1
- in_is_writing_memory  input  1  instruction is a store
- in_flags  input  4  {carry, negative, overflow, zero}
- in_destination_value  input  32  result, or store data
- in_has_upper_value  input  1  in_upper_value is valid (mul/div)
- in_upper_value  input  32  upper result
- in_adjustment_value  input  32  store address offset
- in_has_flushed  input  1  instruction was squashed; retire with no side effects
- registers  output  NREGS*32  register file, register i at bits [32i+31:32i]
- mem_write  output  1  memory write request
- mem_address  output  32  write address
- mem_data  output  32  write data
- mem_ack  input  1  memory accepted the write
- retired_pc  output  32  PC of the last retired instruction

Behaviour:
- Reset, in the same cycle that reset is sampled high:
  - all registers become 0;
  - state becomes IDLE;
  - mem_write, mem_address, mem_data, retired_pc and in_hold become 0.
- Reset takes priority in every state, including MEM_WAIT. A pending store is abandoned and mem_write drops the next cycle.
- States: IDLE, UPPER, MEM_WAIT. The instruction is accepted when in_is_valid=1 and state=IDLE, and all fields are captured internally.
- in_hold = (state != IDLE), registered.
- Flushed instruction (in_has_flushed=1):
  - accepted in one cycle with no register, flags or memory effect;
  - retired_pc is not updated.
- Plain ALU instruction (in_is_writing_memory=0, in_has_upper_value=0), one cycle:
  - Flags[30:27] <= in_flags in this order: carry=30, negative=29, overflow=28, zero=27;
  - then reg[rd] <= in_destination_value. If rd=FLAGS_REG, the destination value overrides the flags write;
  - retired_pc <= in_pc.
- Upper instruction:
  - Accept cycle writes the low value and flags, as for a plain instruction.
  - State goes to UPPER. Next cycle writes reg[(rd+1)] <= in_upper_value, then returns to IDLE. Latency is 2 cycles and the upstream is stalled 1 cycle.
  - If rd=NREGS-1, the upper value is discarded; UPPER is still entered for uniform timing.
- Store (in_is_writing_memory=1):
  - At acceptance: mem_address <= reg[rd] + in_adjustment_value (32-bit wrap), using the register file contents before this cycle's writes; mem_data <= in_destination_value; mem_write <= 1; state goes to MEM_WAIT.
  - Flags are not updated.
  - In MEM_WAIT, mem_write stays high until mem_ack is sampled high. That cycle drops mem_write, sets retired_pc and returns to IDLE.
  - mem_ack outside MEM_WAIT is ignored.
  - Minimum store occupancy is 2 cycles.
- Failed conditional store: execute presents rd=0 and in_is_writing_memory=0. This is treated as a plain instruction, which updates only the flags because register 0 writes are ignored.
- Back-to-back plain instructions retire one per cycle with in_hold=0.
- A new instruction is never accepted in UPPER or MEM_WAIT. The instruction held by execute is accepted on the first IDLE cycle.
- in_is_valid=0 in IDLE: nothing changes.

Optional Feature:
- Macro: WRITE_BACK_STATS_EN.
- When defined, adds two outputs: retired_count (32) and stall_count (32).
  - retired_count increments on every non-flushed retirement.
  - stall_count increments on every cycle with in_hold=1 and in_is_valid=1.
  - Both are cleared by reset and wrap at 2^32.
- When undefined, neither port nor counter logic exists.

Test Plan:
- Reset, then plain instruction rd=5, value 0x12345678, flags 4'b1001 → next cycle reg5=0x12345678, Flags[30:27]=4'b1001, retired_pc=in_pc, in_hold stays 0.
- Upper instruction rd=7, low 0xDEADBEEF, upper 0x00000001 → reg7 written at cycle 1, reg8=1 at cycle 2, in_hold high exactly 1 cycle.
- Upper instruction with rd=31 → reg31 written, no other register changes, 2-cycle occupancy.
- Store with reg3=0x1000, rd=3, offset 0x10, data 0xAA; mem_ack asserted after 3 cycles → mem_address=0x1010, mem_data=0xAA, mem_write held until ack, in_hold high until IDLE, Flags unchanged.
- Flushed instruction rd=4 followed by plain instruction rd=4 value 9 → reg4 ends at 9, no mem_write, retired_pc equals the second instruction's PC.
- Reset asserted during MEM_WAIT → next cycle mem_write=0, all registers 0, state IDLE; a subsequent plain instruction retires normally.
